// File: rtl/rr_bus_arbiter_mux_if.sv
// Purpose : bus bundle between N word sources / one consumer and the
//           registered round-robin bus arbiter-multiplexer.
// Signals : req       - per-source request (bit i = source i)
//           in_data   - flattened source words, source i at [i*WIDTH +: WIDTH]
//           rr_en     - 1 = round-robin, 0 = fixed priority (lowest index)
//           out_ready - consumer accepts out_data when out_valid=1
//           grant     - one-hot capture strobe (combinational)
//           out_valid - out_data holds an unaccepted word
//           out_data  - captured word
//           out_sel   - index of the source that produced out_data
// Modports: master = sources/consumer side, slave = arbiter side.
interface rr_bus_arbiter_mux_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 32
);
    localparam int unsigned SEL_W = $clog2(N);

    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] in_data;
    logic               rr_en;
    logic               out_ready;
    logic [N-1:0]       grant;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;

    modport master (
        output req, in_data, rr_en, out_ready,
        input  grant, out_valid, out_data, out_sel
    );

    modport slave (
        input  req, in_data, rr_en, out_ready,
        output grant, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_bus_arbiter_mux.sv
// Purpose : arbitrates among N bus sources (round-robin or fixed priority,
//           chosen at runtime) and captures the winner's word into an output
//           register that drives a valid/ready handshake.
// Ports   : clock - rising-edge clock
//           clear - synchronous active-high reset
//           bus   - rr_bus_arbiter_mux_if.slave (req/in_data/rr_en/out_ready
//                   in; grant/out_valid/out_data/out_sel out). Only grant is
//                   combinational; all other outputs are registered.
module rr_bus_arbiter_mux #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 32
) (
    input  logic                 clock,
    input  logic                 clear,
    rr_bus_arbiter_mux_if.slave  bus
);
    localparam int unsigned SEL_W = $clog2(N);
    // One extra bit so last+1+offset (at most 2N-1) never overflows.
    localparam int unsigned EXT_W = SEL_W + 1;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic [SEL_W-1:0]   r_out_sel;
    logic [SEL_W-1:0]   r_last;

    logic               w_capture_en;
    logic [EXT_W-1:0]   w_shamt;
    logic [2*N-1:0]     w_req_dbl;
    logic [N-1:0]       w_req_rot;
    logic [EXT_W-1:0]   w_rr_off;
    logic [EXT_W-1:0]   w_rr_sum;
    logic [SEL_W-1:0]   w_rr_winner;
    logic [SEL_W-1:0]   w_fp_winner;
    logic [SEL_W-1:0]   w_winner;
    logic [WIDTH-1:0]   w_win_data;
    logic [N-1:0]       w_grant;

    assign w_capture_en = (|bus.req) & (~r_out_valid | bus.out_ready) & ~clear;

    // Round-robin: rotate req so bit 0 is index last+1, then take the lowest
    // set bit. Doubling the vector makes the rotation wrap modulo N even when
    // N is not a power of two, so indices >= N can never be produced.
    always_comb begin
        w_shamt     = EXT_W'(r_last) + EXT_W'(1);
        w_req_dbl   = {bus.req, bus.req};
        w_req_rot   = N'(w_req_dbl >> w_shamt);
        w_rr_off    = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (w_req_rot[i]) w_rr_off = EXT_W'(i);
        end
        w_rr_sum    = w_shamt + w_rr_off;
        if (w_rr_sum >= EXT_W'(N)) w_rr_sum = w_rr_sum - EXT_W'(N);
        w_rr_winner = w_rr_sum[SEL_W-1:0];
    end

    // Fixed priority: lowest set request index wins.
    always_comb begin
        w_fp_winner = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (bus.req[i]) w_fp_winner = SEL_W'(i);
        end
    end

    // Winner index, its data word and the one-hot grant strobe.
    always_comb begin
        w_winner   = bus.rr_en ? w_rr_winner : w_fp_winner;
        w_win_data = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (w_winner == SEL_W'(i)) w_win_data = bus.in_data[i*WIDTH +: WIDTH];
        end
        w_grant    = w_capture_en ? (N'(1) << w_winner) : '0;
    end

    // Output register; out_valid alone encodes EMPTY/FULL.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_last      <= SEL_W'(N - 1);
        end else if (w_capture_en) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_win_data;
            r_out_sel   <= w_winner;
            // Pointer advances in both modes so a later switch to
            // round-robin resumes after the most recent winner.
            r_last      <= w_winner;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.grant     = w_grant;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;
endmodule
